// File: rtl/mean_restore.sv
// Adds a per-row mean back onto a mean-centred, row-major sample stream.
// Means for one frame are loaded first, then the frame's samples stream through a one-entry output register.
module mean_restore #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mean_valid,
  input  logic [WIDTH-1:0] mean_data,
  output logic             mean_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int AW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int BW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;

  typedef enum logic {LOAD_MEAN, STREAM} state_t;

  state_t           state;
  logic [AW-1:0]    mrow;
  logic [AW-1:0]    row;
  logic [BW-1:0]    col;
  logic [WIDTH-1:0] mean_mem [SIZE_A];

  logic mean_hs;
  logic in_hs;
  logic out_hs;
  logic last_col;
  logic last_row;

  assign mean_ready = (state == LOAD_MEAN);
  assign in_ready   = (state == STREAM) && (!out_valid || out_ready);
  assign busy       = (state != LOAD_MEAN) || out_valid;

  assign mean_hs  = mean_valid && mean_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign last_col = (col == BW'(SIZE_B - 1));
  assign last_row = (row == AW'(SIZE_A - 1));

  // Mean storage is deliberately not reset; a new frame always reloads every row.
  always_ff @(posedge clk) begin
    if (mean_hs) begin
      mean_mem[mrow] <= mean_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_MEAN;
      mrow      <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      // A pending output may drain while the next frame's means are loading.
      if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state)
        LOAD_MEAN: begin
          if (mean_hs) begin
            if (mrow == AW'(SIZE_A - 1)) begin
              mrow  <= '0;
              state <= STREAM;
            end else begin
              mrow <= mrow + AW'(1);
            end
          end
        end
        STREAM: begin
          if (in_hs) begin
            out_data  <= in_data + mean_mem[row];
            out_valid <= 1'b1;
            out_last  <= last_col && last_row;
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                state <= LOAD_MEAN;
              end else begin
                row <= row + AW'(1);
              end
            end else begin
              col <= col + BW'(1);
            end
          end
        end
        default: state <= LOAD_MEAN;
      endcase
    end
  end

endmodule
